bias_ctrl: RTL and testbench

Sequencer for the per-column `bias` stage that sits below the systolic array. It streams one layer's bias vector (one Q8.8 word per column) from the unified-buffer load path into held registers. It presents each column's bias to that column's `bias` unit, then counts rows leaving the last column until the layer completes. It frees the top-level controller from tracking bias state per layer.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/bias_bank.sv | 37 +++
 rtl/bias_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_bias_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types for the systolic-array datapath: Q8.8 word, bias sequencer states.
package tpu_pkg;

  localparam int BIAS_W = 16;

  typedef logic signed [BIAS_W-1:0] fxp16_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } bias_state_e;

endpackage

// File: rtl/bias_bank.sv
// NUM_COLS x 16 bias register file: one indexed write port, flat parallel read, bulk load.
// An indexed write wins over a bulk load for the same column in the same cycle.
module bias_bank
  import tpu_pkg::*;
#(
  parameter int NUM_COLS = 2,
  parameter int IDX_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  fxp16_t                     wr_data_i,
  input  logic                       bulk_en_i,
  input  logic [NUM_COLS*BIAS_W-1:0] bulk_data_i,
  output logic [NUM_COLS*BIAS_W-1:0] rd_data_o
);

  logic [NUM_COLS*BIAS_W-1:0] bank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
    end else begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (wr_en_i && (wr_idx_i == IDX_W'(c))) begin
          bank_q[c*BIAS_W +: BIAS_W] <= wr_data_i;
        end else if (bulk_en_i) begin
          bank_q[c*BIAS_W +: BIAS_W] <= bulk_data_i[c*BIAS_W +: BIAS_W];
        end
      end
    end
  end

  assign rd_data_o = bank_q;

endmodule

// File: rtl/bias_ctrl.sv
// Bias sequencer: loads one layer's bias vector, holds it for the columns, counts rows out.
// Define BIAS_CTRL_DBUF_EN to add a shadow bank so the next layer loads while this one runs.
module bias_ctrl
  import tpu_pkg::*;
#(
  parameter int NUM_COLS = 2,
  parameter int ROW_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [ROW_W-1:0]           cfg_num_rows,
  input  logic                       ld_valid_in,
  input  logic [BIAS_W-1:0]          ld_data_in,
  output logic                       ld_ready_out,
  input  logic [NUM_COLS-1:0]        col_valid_in,
  output logic [NUM_COLS*BIAS_W-1:0] bias_temp_bias_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       err_out
);

  localparam int IDX_W = $clog2(NUM_COLS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

  bias_state_e      state_q, state_d;
  logic [ROW_W-1:0] numRows_q, numRows_d;
  logic [ROW_W-1:0] rowCnt_q, rowCnt_d, rowInc;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ldHs, actWrEn;

`ifdef BIAS_CTRL_DBUF_EN
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NUM_COLS);
  logic                       pend_q, pend_d;
  logic [ROW_W-1:0]           pendRows_q, pendRows_d;
  logic                       shWrEn, copyEn;
  logic [NUM_COLS*BIAS_W-1:0] shadowFlat;

  // In RUN idx_q counts words already staged in the shadow bank.
  assign ld_ready_out = (state_q == ST_LOAD) || ((state_q == ST_RUN) && (idx_q != FULL_IDX));
`else
  assign ld_ready_out = (state_q == ST_LOAD);
`endif

  assign ldHs     = ld_valid_in && ld_ready_out;
  assign rowInc   = rowCnt_q + ROW_W'(1);
  assign busy_out = (state_q != ST_IDLE);
  assign done_out = done_q;
  assign err_out  = err_q;

  always_comb begin
    state_d   = state_q;
    numRows_d = numRows_q;
    rowCnt_d  = rowCnt_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    err_d     = err_q;
    actWrEn   = 1'b0;
`ifdef BIAS_CTRL_DBUF_EN
    pend_d     = pend_q;
    pendRows_d = pendRows_q;
    shWrEn     = 1'b0;
    copyEn     = 1'b0;
`endif

    if ((state_q != ST_RUN) && (col_valid_in != '0)) err_d = 1'b1;

    if (cfg_start && (state_q != ST_IDLE)) begin
`ifdef BIAS_CTRL_DBUF_EN
      if (pend_q) begin
        err_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pendRows_d = cfg_num_rows;
      end
`else
      err_d = 1'b1;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          numRows_d = cfg_num_rows;
          rowCnt_d  = '0;
          idx_d     = '0;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (ldHs) begin
          actWrEn = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
`ifdef BIAS_CTRL_DBUF_EN
          shWrEn = 1'b1;
`endif
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef BIAS_CTRL_DBUF_EN
            copyEn = 1'b1;
`endif
            if (numRows_q == '0) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
`ifdef BIAS_CTRL_DBUF_EN
              if (pend_d) begin
                numRows_d = pendRows_d;
                pend_d    = 1'b0;
                state_d   = ST_LOAD;
              end
`endif
            end else begin
              state_d = ST_RUN;
            end
          end
        end
      end

      ST_RUN: begin
`ifdef BIAS_CTRL_DBUF_EN
        if (ldHs) begin
          shWrEn = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
        end
`endif
        if (col_valid_in[NUM_COLS-1]) begin
          rowCnt_d = rowInc;
          if (rowInc == numRows_q) begin
            done_d   = 1'b1;
            rowCnt_d = '0;
            state_d  = ST_IDLE;
`ifdef BIAS_CTRL_DBUF_EN
            // A word landing this cycle reaches the active bank through the indexed port.
            if (pend_d) begin
              numRows_d = pendRows_d;
              pend_d    = 1'b0;
              if (idx_d == FULL_IDX) begin
                copyEn  = 1'b1;
                actWrEn = ldHs;
                idx_d   = '0;
                state_d = (pendRows_d == '0) ? ST_IDLE : ST_RUN;
              end else begin
                state_d = ST_LOAD;
              end
            end
`endif
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      numRows_q <= '0;
      rowCnt_q  <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      numRows_q <= numRows_d;
      rowCnt_q  <= rowCnt_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef BIAS_CTRL_DBUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pendRows_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pendRows_q <= pendRows_d;
    end
  end

  bias_bank #(.NUM_COLS(NUM_COLS), .IDX_W(IDX_W)) uShadow (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (shWrEn),
    .wr_idx_i    (idx_q),
    .wr_data_i   (ld_data_in),
    .bulk_en_i   (1'b0),
    .bulk_data_i ('0),
    .rd_data_o   (shadowFlat)
  );

  bias_bank #(.NUM_COLS(NUM_COLS), .IDX_W(IDX_W)) uActive (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (actWrEn),
    .wr_idx_i    (idx_q),
    .wr_data_i   (ld_data_in),
    .bulk_en_i   (copyEn),
    .bulk_data_i (shadowFlat),
    .rd_data_o   (bias_temp_bias_out)
  );
`else
  bias_bank #(.NUM_COLS(NUM_COLS), .IDX_W(IDX_W)) uActive (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (actWrEn),
    .wr_idx_i    (idx_q),
    .wr_data_i   (ld_data_in),
    .bulk_en_i   (1'b0),
    .bulk_data_i ('0),
    .rd_data_o   (bias_temp_bias_out)
  );
`endif

endmodule

// File: tb/tb_bias_ctrl.sv
// Self-checking bench for bias_ctrl against a simple bias-array / row-count model.
// Scenarios specific to BIAS_CTRL_DBUF_EN are compiled only when that macro is defined.
module tb_bias_ctrl;

  localparam int NUM_COLS = 2;
  localparam int ROW_W    = 16;
  localparam logic [NUM_COLS-1:0] TOP_COL = NUM_COLS'(1) << (NUM_COLS - 1);
`ifdef BIAS_CTRL_DBUF_EN
  localparam logic RUN_READY = 1'b1;
`else
  localparam logic RUN_READY = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfgStart;
  logic [ROW_W-1:0]       cfgNumRows;
  logic                   ldValid;
  logic [15:0]            ldData;
  logic                   ldReady;
  logic [NUM_COLS-1:0]    colValid;
  logic [NUM_COLS*16-1:0] biasOut;
  logic                   busy;
  logic                   done;
  logic                   err;

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] modelBias [NUM_COLS];

  always #5 clk = ~clk;

  bias_ctrl #(.NUM_COLS(NUM_COLS), .ROW_W(ROW_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_start          (cfgStart),
    .cfg_num_rows       (cfgNumRows),
    .ld_valid_in        (ldValid),
    .ld_data_in         (ldData),
    .ld_ready_out       (ldReady),
    .col_valid_in       (colValid),
    .bias_temp_bias_out (biasOut),
    .busy_out           (busy),
    .done_out           (done),
    .err_out            (err)
  );

  function automatic logic [NUM_COLS*16-1:0] modelFlat();
    logic [NUM_COLS*16-1:0] r;
    for (int c = 0; c < NUM_COLS; c++) r[c*16 +: 16] = modelBias[c];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; cfgStart = 1'b0; cfgNumRows = '0; ldValid = 1'b0; ldData = '0; colValid = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) modelBias[c] = '0;
  endtask

  task automatic startLayer(input logic [ROW_W-1:0] rows);
    cfgStart = 1'b1; cfgNumRows = rows;
    tick();
    cfgStart = 1'b0;
  endtask

  task automatic loadAll(input logic [15:0] w0, input logic [15:0] w1);
    ldValid = 1'b1; ldData = w0; tick(); modelBias[0] = w0;
    ldData = w1; tick(); modelBias[1] = w1;
    ldValid = 1'b0;
  endtask

  task automatic pulseRow();
    colValid = TOP_COL;
    tick();
    colValid = '0;
  endtask

  task automatic test_reset();
    doReset();
    assertCount++; if (biasOut !== '0) begin failCount++; $display("[TB] FAIL reset_bias: got %h expected 0", biasOut); end
    assertCount++; if ({ldReady, busy, done, err} !== 4'b0) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 0000", {ldReady, busy, done, err}); end
  endtask

  task automatic test_basic();
    startLayer(16'd3);
    assertCount++; if ({ldReady, busy} !== 2'b11) begin failCount++; $display("[TB] FAIL basic_load_state: got %b expected 11", {ldReady, busy}); end
    ldValid = 1'b1; ldData = 16'h0180; tick(); modelBias[0] = 16'h0180;
    assertCount++; if (biasOut !== modelFlat()) begin failCount++; $display("[TB] FAIL basic_word0: got %h expected %h", biasOut, modelFlat()); end
    ldData = 16'hFF00; tick(); modelBias[1] = 16'hFF00; ldValid = 1'b0;
    assertCount++; if (biasOut !== 32'hFF00_0180) begin failCount++; $display("[TB] FAIL basic_bias: got %h expected ff000180", biasOut); end
    assertCount++; if ({ldReady, busy} !== {RUN_READY, 1'b1}) begin failCount++; $display("[TB] FAIL basic_run_state: got %b expected %b", {ldReady, busy}, {RUN_READY, 1'b1}); end
    for (int r = 0; r < 3; r++) begin
      pulseRow();
      assertCount++; if ({done, busy} !== ((r == 2) ? 2'b10 : 2'b01)) begin failCount++; $display("[TB] FAIL basic_row%0d: got done,busy=%b expected %b", r, {done, busy}, (r == 2) ? 2'b10 : 2'b01); end
    end
    tick();
    assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL basic_done_width: got %b expected 0", done); end
    assertCount++; if (biasOut !== modelFlat()) begin failCount++; $display("[TB] FAIL basic_retain: got %h expected %h", biasOut, modelFlat()); end
  endtask

  task automatic test_zero_rows();
    startLayer(16'd0);
    loadAll(16'h1234, 16'h8001);
    assertCount++; if ({done, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL zero_done: got done,busy=%b expected 10", {done, busy}); end
    assertCount++; if (biasOut !== modelFlat()) begin failCount++; $display("[TB] FAIL zero_bias: got %h expected %h", biasOut, modelFlat()); end
    tick();
    assertCount++; if ({done, busy, ldReady} !== 3'b000) begin failCount++; $display("[TB] FAIL zero_idle: got %b expected 000", {done, busy, ldReady}); end
  endtask

  task automatic test_load_stall();
    startLayer(16'd1);
    ldValid = 1'b1; ldData = 16'h0A0B; tick(); modelBias[0] = 16'h0A0B; ldValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      assertCount++; if ({ldReady, busy} !== 2'b11 || biasOut !== modelFlat()) begin failCount++; $display("[TB] FAIL stall_hold%0d: got ready,busy=%b bias=%h expected 11 %h", i, {ldReady, busy}, biasOut, modelFlat()); end
    end
    ldValid = 1'b1; ldData = 16'h7FFF; tick(); modelBias[1] = 16'h7FFF; ldValid = 1'b0;
    assertCount++; if (biasOut !== modelFlat()) begin failCount++; $display("[TB] FAIL stall_final: got %h expected %h", biasOut, modelFlat()); end
    pulseRow();
    assertCount++; if ({done, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL stall_done: got %b expected 10", {done, busy}); end
  endtask

  task automatic test_err();
    doReset();
    colValid = 2'b01; tick(); colValid = '0;
    assertCount++; if (err !== 1'b1) begin failCount++; $display("[TB] FAIL err_idle_valid: got %b expected 1", err); end
    tick(); tick();
    startLayer(16'd1);
    loadAll(16'h0001, 16'h0002);
    pulseRow();
    assertCount++; if ({done, err} !== 2'b11) begin failCount++; $display("[TB] FAIL err_sticky_count: got done,err=%b expected 11", {done, err}); end
    doReset();
    assertCount++; if (err !== 1'b0) begin failCount++; $display("[TB] FAIL err_cleared: got %b expected 0", err); end
`ifndef BIAS_CTRL_DBUF_EN
    startLayer(16'd2);
    loadAll(16'h0003, 16'h0004);
    cfgStart = 1'b1; cfgNumRows = 16'd9; tick(); cfgStart = 1'b0;
    assertCount++; if ({err, busy} !== 2'b11) begin failCount++; $display("[TB] FAIL err_busy_start: got err,busy=%b expected 11", {err, busy}); end
    pulseRow();
    pulseRow();
    assertCount++; if ({done, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL err_start_ignored: got %b expected 10", {done, busy}); end
    doReset();
`endif
  endtask

  task automatic test_abort();
    doReset();
    startLayer(16'd3);
    loadAll(16'h1111, 16'h2222);
    pulseRow();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) modelBias[c] = '0;
    assertCount++; if ({ldReady, busy, done, err} !== 4'b0 || biasOut !== '0) begin failCount++; $display("[TB] FAIL abort_outputs: got flags=%b bias=%h expected 0000 0", {ldReady, busy, done, err}, biasOut); end
    for (int i = 0; i < 4; i++) begin
      colValid = '0; tick();
      assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL abort_no_done%0d: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_back_to_back();
    startLayer(16'd1);
    loadAll(16'hABCD, 16'h00EF);
    pulseRow();
    assertCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_done: got %b expected 1", done); end
    startLayer(16'd1);
    assertCount++; if ({busy, ldReady, done} !== 3'b110) begin failCount++; $display("[TB] FAIL b2b_accept: got %b expected 110", {busy, ldReady, done}); end
    loadAll(16'h5555, 16'hAAAA);
    pulseRow();
    assertCount++; if ({done, busy} !== 2'b10 || biasOut !== modelFlat()) begin failCount++; $display("[TB] FAIL b2b_second: got %b %h expected 10 %h", {done, busy}, biasOut, modelFlat()); end
  endtask

  task automatic test_random();
    int rows;
    for (int layer = 0; layer < 20; layer++) begin
      rows = $urandom_range(0, 5);
      startLayer(ROW_W'(rows));
      for (int c = 0; c < NUM_COLS; c++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          ldValid = 1'b0; tick();
          assertCount++; if (ldReady !== 1'b1) begin failCount++; $display("[TB] FAIL rand_gap_ready: got %b expected 1", ldReady); end
        end
        ldValid = 1'b1; ldData = 16'($urandom);
        modelBias[c] = ldData;
        tick();
        ldValid = 1'b0;
        assertCount++; if (biasOut !== modelFlat()) begin failCount++; $display("[TB] FAIL rand_bias L%0d c%0d: got %h expected %h", layer, c, biasOut, modelFlat()); end
      end
      if (rows == 0) begin
        assertCount++; if ({done, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL rand_zero_done: got %b expected 10", {done, busy}); end
      end
      for (int r = 0; r < rows; r++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          colValid = NUM_COLS'($urandom) & ~TOP_COL; tick();
          assertCount++; if ({done, busy} !== 2'b01) begin failCount++; $display("[TB] FAIL rand_gap: got %b expected 01", {done, busy}); end
        end
        pulseRow();
        assertCount++; if ({done, busy} !== ((r == rows - 1) ? 2'b10 : 2'b01)) begin failCount++; $display("[TB] FAIL rand_row L%0d r%0d: got %b", layer, r, {done, busy}); end
      end
    end
    assertCount++; if (err !== 1'b0) begin failCount++; $display("[TB] FAIL rand_err: got %b expected 0", err); end
  endtask

`ifdef BIAS_CTRL_DBUF_EN
  task automatic test_dbuf();
    doReset();
    startLayer(16'd2);
    loadAll(16'h0011, 16'h0022);
    ldValid = 1'b1; ldData = 16'h0100;
    assertCount++; if (ldReady !== 1'b1) begin failCount++; $display("[TB] FAIL dbuf_ready: got %b expected 1", ldReady); end
    tick(); ldData = 16'h0200; tick(); ldValid = 1'b0;
    cfgStart = 1'b1; cfgNumRows = 16'd1; tick(); cfgStart = 1'b0;
    assertCount++; if ({err, biasOut} !== {1'b0, modelFlat()}) begin failCount++; $display("[TB] FAIL dbuf_hold: got %b %h expected 0 %h", err, biasOut, modelFlat()); end
    pulseRow();
    pulseRow();
    modelBias[0] = 16'h0100; modelBias[1] = 16'h0200;
    assertCount++; if ({done, busy} !== 2'b11 || biasOut !== modelFlat()) begin failCount++; $display("[TB] FAIL dbuf_swap: got %b %h expected 11 %h", {done, busy}, biasOut, modelFlat()); end
    pulseRow();
    assertCount++; if ({done, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL dbuf_second_done: got %b expected 10", {done, busy}); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_load_stall();
    test_err();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef BIAS_CTRL_DBUF_EN
    test_dbuf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
